// File: rtl/pma_region_pkg.sv
// Shared types and the region-match helper for the sequential PMA region walker.
package pma_region_pkg;

  localparam int unsigned MaxRules      = 16;
  localparam int unsigned RuleAddrWidth = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } walker_state_e;

  typedef struct packed {
    logic [RuleAddrWidth-1:0] base;
    logic [RuleAddrWidth-1:0] length;
  } rule_t;

  // Exclusive-end compare carried in one extra bit so a region reaching 2^64 still matches its top address.
  function automatic logic in_region(input logic [RuleAddrWidth-1:0] addr, input rule_t rule);
    logic [RuleAddrWidth:0] region_end;
    region_end = {1'b0, rule.base} + {1'b0, rule.length};
    return (rule.length != '0) && (addr >= rule.base) && ({1'b0, addr} < region_end);
  endfunction

endpackage

// File: rtl/pma_range_cmp.sv
// Single-rule region comparator; the walker time-multiplexes it across the rule table.
module pma_range_cmp
  import pma_region_pkg::*;
(
  input  rule_t                    rule,
  input  logic [RuleAddrWidth-1:0] addr,
  output logic                     match_c
);

  assign match_c = in_region(addr, rule);

endmodule

// File: rtl/pma_region_walker.sv
// Sequential PMA region lookup: one rule compared per cycle, lowest matching index wins.
module pma_region_walker
  import pma_region_pkg::*;
#(
  parameter int unsigned NrRules   = 3,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned IdWidth   = 2
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             flush_i,
  input  logic [((NrRules > 0) ? NrRules : 1)*AddrWidth-1:0] base_i,
  input  logic [((NrRules > 0) ? NrRules : 1)*AddrWidth-1:0] length_i,
  input  logic                                             req_valid_i,
  output logic                                             req_ready_o,
  input  logic [AddrWidth-1:0]                             req_addr_i,
  input  logic [IdWidth-1:0]                               req_id_i,
  output logic                                             rsp_valid_o,
  input  logic                                             rsp_ready_i,
  output logic                                             rsp_hit_o,
  output logic [$clog2((NrRules > 2) ? NrRules : 2)-1:0]   rsp_idx_o,
  output logic [IdWidth-1:0]                               rsp_id_o,
  output logic                                             busy_o
);

  localparam int unsigned NrSlots  = (NrRules > 0) ? NrRules : 1;
  localparam int unsigned IdxWidth = $clog2((NrRules > 2) ? NrRules : 2);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'((NrRules > 0) ? (NrRules - 1) : 0);

  if (NrRules > MaxRules) begin : g_rules_check
    $error("pma_region_walker: NrRules exceeds MaxRules");
  end
  if (AddrWidth > RuleAddrWidth) begin : g_width_check
    $error("pma_region_walker: AddrWidth exceeds rule field width");
  end

  walker_state_e               state_q, state_d;
  logic [AddrWidth-1:0]        addr_q;
  logic [IdWidth-1:0]          id_q;
  logic [IdxWidth-1:0]         idx_q;
  rule_t                       rules [NrSlots];
  rule_t                       cur_rule;
  logic [RuleAddrWidth-1:0]    addr_ext;
  logic                        match_c;
  logic                        accept_c;
  logic                        last_c;

  // Unpack the flat table into rule structs, zero-extended to the comparator width.
  for (genvar k = 0; k < NrSlots; k++) begin : g_unpack
    assign rules[k].base   = RuleAddrWidth'(base_i[k*AddrWidth +: AddrWidth]);
    assign rules[k].length = RuleAddrWidth'(length_i[k*AddrWidth +: AddrWidth]);
  end

  always_comb begin
    cur_rule = '0;
    for (int unsigned k = 0; k < NrSlots; k++) begin
      if (idx_q == IdxWidth'(k)) cur_rule = rules[k];
    end
  end

  assign addr_ext = RuleAddrWidth'(addr_q);

  pma_range_cmp u_cmp (
    .rule    (cur_rule),
    .addr    (addr_ext),
    .match_c (match_c)
  );

  assign accept_c = (state_q == IDLE) && req_valid_i && !flush_i;
  assign last_c   = (idx_q == LastIdx);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Flush overrides every transition; an empty table skips straight to the response.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (req_valid_i) state_d = (NrRules > 0) ? SCAN : RESP;
        SCAN:    if (match_c || last_c) state_d = RESP;
        RESP:    if (rsp_ready_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      RESP:    rsp_valid_o = 1'b1;
      default: ;
    endcase
  end

  // Query registers and response payload; payload only changes on the way into RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q    <= '0;
      id_q      <= '0;
      idx_q     <= '0;
      rsp_hit_o <= 1'b0;
      rsp_idx_o <= '0;
      rsp_id_o  <= '0;
    end else if (accept_c) begin
      addr_q <= req_addr_i;
      id_q   <= req_id_i;
      idx_q  <= '0;
      if (NrRules == 0) begin
        rsp_hit_o <= 1'b0;
        rsp_idx_o <= '0;
        rsp_id_o  <= req_id_i;
      end
    end else if (!flush_i && (state_q == SCAN)) begin
      if (match_c) begin
        rsp_hit_o <= 1'b1;
        rsp_idx_o <= idx_q;
        rsp_id_o  <= id_q;
      end else if (last_c) begin
        rsp_hit_o <= 1'b0;
        rsp_idx_o <= '0;
        rsp_id_o  <= id_q;
        idx_q     <= '0;
      end else begin
        idx_q <= idx_q + IdxWidth'(1);
      end
    end
  end

endmodule
